// File: rtl/byte_serial_subtractor.sv
// Byte-serial two's-complement subtractor: D = A - B computed one byte per clock
// with a registered carry chain. Define SUB_SATURATE_EN to clamp D on signed overflow.
module byte_serial_subtractor #(
  parameter int NBYTES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   D,
  output logic                  borrow,
  output logic                  ovf,
  output logic                  zero
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_accept;
  logic            w_step;
  logic            w_last;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_nb;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_d;
  logic            r_borrow;
  logic            r_ovf;
  logic            r_zero;

  logic [7:0]      w_a_byte;
  logic [7:0]      w_b_byte;
  logic [8:0]      w_sum;
  logic [W-1:0]    w_d_step;
  logic [W-1:0]    w_d_final;
  logic            w_ovf;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        w_step = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Byte lane selected by the step index; the subtrahend is already inverted.
  always_comb begin
    w_a_byte = '0;
    w_b_byte = '0;
    w_d_step = r_d;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (r_idx == IW'(i)) begin
        w_a_byte = r_a[8*i +: 8];
        w_b_byte = r_nb[8*i +: 8];
      end
    end
    w_sum = {1'b0, w_a_byte} + {1'b0, w_b_byte} + {8'd0, r_carry};
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (r_idx == IW'(i)) w_d_step[8*i +: 8] = w_sum[7:0];
    end
  end

  // r_nb holds ~B, so equal MSBs here mean the operand signs differ.
  assign w_ovf = (r_a[W-1] == r_nb[W-1]) & (w_d_step[W-1] != r_a[W-1]);

`ifdef SUB_SATURATE_EN
  assign w_d_final = w_ovf ? (r_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                           : w_d_step;
`else
  assign w_d_final = w_d_step;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_nb     <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_nb    <= ~B;
      r_carry <= 1'b1;
      r_idx   <= '0;
    end else if (w_step) begin
      r_carry <= w_sum[8];
      if (w_last) begin
        r_d      <= w_d_final;
        r_borrow <= ~w_sum[8];
        r_ovf    <= w_ovf;
        r_zero   <= (w_d_final == '0);
        r_idx    <= '0;
      end else begin
        r_d   <= w_d_step;
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign D         = r_d;
  assign borrow    = r_borrow;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_byte_serial_subtractor.sv
// Directed self-checking bench for byte_serial_subtractor (NBYTES=4).
module tb_byte_serial_subtractor;

  localparam int NB = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] D;
  logic        borrow;
  logic        ovf;
  logic        zero;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  byte_serial_subtractor #(.NBYTES(NB)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .borrow    (borrow),
    .ovf       (ovf),
    .zero      (zero)
  );

  // Accept one operation and wait for out_valid; lat counts the accept edge, -1 on timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    int n;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      lat = -1;
      return;
    end
    A = a;
    B = b;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    A = 32'hA5A5_A5A5;
    B = 32'h5A5A_5A5A;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    lat = out_valid ? n + 1 : -1;
  endtask

  task automatic handoff(output logic ov_after, output logic ir_after);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    ov_after = out_valid;
    ir_after = in_ready;
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (D !== 32'h0) begin errors++; $display("FAIL reset_D: got %h expected 00000000", D); end
    checks++; if ({borrow, ovf, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {borrow, ovf, zero}); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    logic ov_a, ir_a;
    run_op(32'h0000_0005, 32'h0000_0003, lat);
    checks++; if (lat !== NB + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, NB + 1); end
    checks++; if (D !== 32'h0000_0002) begin errors++; $display("FAIL basic_D: got %h expected 00000002", D); end
    checks++; if ({borrow, ovf, zero} !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b expected 000", {borrow, ovf, zero}); end
    handoff(ov_a, ir_a);
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL basic_handoff_valid: got %b expected 0", ov_a); end
    checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL basic_handoff_ready: got %b expected 1", ir_a); end
  endtask

  task automatic test_borrow_ripple;
    int lat;
    logic ov_a, ir_a;
    run_op(32'h0000_0000, 32'h0000_0001, lat);
    checks++; if (lat !== NB + 1) begin errors++; $display("FAIL ripple_latency: got %0d expected %0d", lat, NB + 1); end
    checks++; if (D !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ripple_D: got %h expected ffffffff", D); end
    checks++; if ({borrow, ovf, zero} !== 3'b100) begin errors++; $display("FAIL ripple_flags: got %b expected 100", {borrow, ovf, zero}); end
    handoff(ov_a, ir_a);
  endtask

  task automatic test_overflow;
    int lat;
    logic ov_a, ir_a;
    logic [31:0] exp_d1, exp_d2;
`ifdef SUB_SATURATE_EN
    exp_d1 = 32'h8000_0000;
    exp_d2 = 32'h7FFF_FFFF;
`else
    exp_d1 = 32'h7FFF_FFFF;
    exp_d2 = 32'h8000_0000;
`endif
    run_op(32'h8000_0000, 32'h0000_0001, lat);
    checks++; if (D !== exp_d1) begin errors++; $display("FAIL ovf_neg_D: got %h expected %h", D, exp_d1); end
    checks++; if ({borrow, ovf, zero} !== 3'b010) begin errors++; $display("FAIL ovf_neg_flags: got %b expected 010", {borrow, ovf, zero}); end
    handoff(ov_a, ir_a);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++; if (D !== exp_d2) begin errors++; $display("FAIL ovf_pos_D: got %h expected %h", D, exp_d2); end
    checks++; if ({borrow, ovf, zero} !== 3'b110) begin errors++; $display("FAIL ovf_pos_flags: got %b expected 110", {borrow, ovf, zero}); end
    handoff(ov_a, ir_a);
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    logic ov_a, ir_a;
    run_op(32'h1234_5678, 32'h1234_5678, lat);
    checks++; if (D !== 32'h0) begin errors++; $display("FAIL equal_D: got %h expected 00000000", D); end
    checks++; if ({borrow, ovf, zero} !== 3'b001) begin errors++; $display("FAIL equal_flags: got %b expected 001", {borrow, ovf, zero}); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      A = 32'hFFFF_FFFF;
      B = 32'h0000_0001;
      @(negedge clock);
      if (out_valid !== 1'b1 || D !== 32'h0 || zero !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable: got %0d bad cycles expected 0", bad); end
    handoff(ov_a, ir_a);
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL hold_handoff_valid: got %b expected 0", ov_a); end
    checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL hold_handoff_ready: got %b expected 1", ir_a); end
    repeat (6) @(negedge clock);
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL ignored_input: got %b expected 01", {out_valid, in_ready}); end
  endtask

  task automatic test_reset_mid_busy;
    int lat;
    logic ov_a, ir_a;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_pre_ready: got %b expected 1", in_ready); end
    A = 32'h0F0F_0F0F;
    B = 32'h0101_0101;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    checks++; if (D[7:0] !== 8'h0E) begin errors++; $display("FAIL midrst_byte0: got %h expected 0e", D[7:0]); end
    reset_n = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL midrst_hs: got %b expected 10", {in_ready, out_valid}); end
    checks++; if (D !== 32'h0) begin errors++; $display("FAIL midrst_D: got %h expected 00000000", D); end
    #1 reset_n = 1'b1;
    run_op(32'h0000_0100, 32'h0000_0001, lat);
    checks++; if (lat !== NB + 1) begin errors++; $display("FAIL postrst_latency: got %0d expected %0d", lat, NB + 1); end
    checks++; if (D !== 32'h0000_00FF) begin errors++; $display("FAIL postrst_D: got %h expected 000000ff", D); end
    checks++; if ({borrow, ovf, zero} !== 3'b000) begin errors++; $display("FAIL postrst_flags: got %b expected 000", {borrow, ovf, zero}); end
    handoff(ov_a, ir_a);
  endtask

  task automatic test_back_to_back;
    int acc[$];
    int nres;
    int bad_d;
    int bad_gap;
    nres = 0;
    bad_d = 0;
    bad_gap = 0;
    @(negedge clock);
    out_ready = 1'b1;
    in_valid = 1'b1;
    A = 32'h0000_0010;
    B = 32'h0000_0003;
    for (int c = 0; c < 42; c++) begin
      if (in_ready) acc.push_back(c);
      if (out_valid) begin
        nres++;
        if (D !== 32'h0000_000D || borrow !== 1'b0) bad_d++;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 1; k < acc.size(); k++)
      if (acc[k] - acc[k-1] != NB + 2) bad_gap++;
    checks++; if (acc.size() !== 7) begin errors++; $display("FAIL b2b_accepts: got %0d expected 7", acc.size()); end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL b2b_spacing: got %0d bad gaps expected 0", bad_gap); end
    checks++; if (nres !== 7) begin errors++; $display("FAIL b2b_results: got %0d expected 7", nres); end
    checks++; if (bad_d !== 0) begin errors++; $display("FAIL b2b_D: got %0d bad results expected 0", bad_d); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_borrow_ripple;
    test_overflow;
    test_backpressure;
    test_reset_mid_busy;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
